// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the multi-channel SRAM access controller.
// Latency: n/a (types, parameters and a width helper only).
// Backpressure: n/a.
package risc_mem_pkg;

    // Default parameter values for the controller.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_NCH    = 2;
    localparam int DEF_RD_LAT = 1;
    localparam int DEF_LEN_W  = 4;

    // SRAM enables are active-low.
    localparam logic MEM_EN_ON  = 1'b0;
    localparam logic MEM_EN_OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after ptr.
// Latency: combinational.
// Backpressure: none; grant is only meaningful when the caller samples it.
//
// Ports:
//   req   - per-channel request vector
//   ptr   - index of the last granted channel; search starts at ptr+1
//   grant - one-hot winner, all zero when no request is present
module rr_arbiter
    import risc_mem_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic [NCH-1:0]          req,
    input  logic [ptr_w(NCH)-1:0]   ptr,
    output logic [NCH-1:0]          grant
);

    logic found;

    // Walk priority slots ptr+1, ptr+2, ... ptr+NCH (mod NCH); first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            for (int j = 0; j < NCH; j++) begin
                if (!found && req[j] && (((int'(ptr) + k) % NCH) == j)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-channel SRAM access controller: RR arbitration, single-word writes, burst reads.
// Latency: gnt and first address 1 cycle after pick; read data RD_LAT+1 cycles after its address cycle.
// Backpressure: requesters hold req until gnt; new requests are only arbitrated in IDLE.
//
// Ports:
//   clk, rst_n                      - clock, async active-low reset
//   req/we/addr/len/wdata           - per-channel request, op, start address, burst len-1, write data
//   gnt/rvalid/done                 - per-channel accept, read-word and completion pulses
//   rdata                           - shared read data, valid with any rvalid bit
//   mem_cen/mem_wen/mem_oen         - active-low SRAM enables
//   mem_addr/mem_datain/mem_dataout - SRAM address, write data, read data
module mem_access_ctrl
    import risc_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NCH    = DEF_NCH,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        we,
    input  logic [NCH*ADDR_W-1:0] addr,
    input  logic [NCH*LEN_W-1:0]  len,
    input  logic [NCH*DATA_W-1:0] wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [NCH-1:0]        done,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic                  mem_oen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_datain,
    input  logic [DATA_W-1:0]     mem_dataout
);

    localparam int PTR_W = ptr_w(NCH);

    state_t              state;
    logic [NCH-1:0]      owner;      // one-hot owner of the current transaction
    logic [PTR_W-1:0]    ptr;        // last granted channel
    logic                we_l;
    logic [LEN_W-1:0]    len_l;
    logic [LEN_W-1:0]    cnt;        // index of the word in the current address cycle
    logic [RD_LAT-1:0]   rd_pipe;    // stage i set => a read address cycle was i+1 cycles ago
    logic [RD_LAT-1:0]   last_pipe;  // marks the final word of the burst in rd_pipe

    logic [NCH-1:0]      arb_gnt;
    logic [PTR_W-1:0]    win_idx;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [LEN_W-1:0]    win_len;
    logic [DATA_W-1:0]   win_wdata;

    logic                issue_rd;
    logic                issue_last;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt)
    );

    // Select the winner's request fields.
    always_comb begin
        win_idx   = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_len   = '0;
        win_wdata = '0;
        for (int j = 0; j < NCH; j++) begin
            if (arb_gnt[j]) begin
                win_idx   = PTR_W'(j);
                win_we    = we[j];
                win_addr  = addr[j*ADDR_W +: ADDR_W];
                win_len   = len[j*LEN_W +: LEN_W];
                win_wdata = wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    assign issue_rd   = (state == ST_ISSUE) && !we_l;
    assign issue_last = issue_rd && (cnt == len_l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= '0;
            ptr        <= PTR_W'(NCH - 1);
            we_l       <= 1'b0;
            len_l      <= '0;
            cnt        <= '0;
            rd_pipe    <= '0;
            last_pipe  <= '0;
            gnt        <= '0;
            rvalid     <= '0;
            done       <= '0;
            rdata      <= '0;
            mem_cen    <= MEM_EN_OFF;
            mem_wen    <= MEM_EN_OFF;
            mem_oen    <= MEM_EN_OFF;
            mem_addr   <= '0;
            mem_datain <= '0;
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            done   <= '0;

            // Read return pipeline: the top stage holds a word whose SRAM data is on
            // mem_dataout this cycle, so it is registered out now.
            rd_pipe[0]   <= issue_rd;
            last_pipe[0] <= issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i]   <= rd_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (rd_pipe[RD_LAT-1]) begin
                rdata  <= mem_dataout;
                rvalid <= owner;
                if (last_pipe[RD_LAT-1]) begin
                    done <= owner;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        owner    <= arb_gnt;
                        ptr      <= win_idx;
                        we_l     <= win_we;
                        len_l    <= win_len;
                        cnt      <= '0;
                        gnt      <= arb_gnt;
                        mem_cen  <= MEM_EN_ON;
                        mem_addr <= win_addr;
                        if (win_we) begin
                            mem_wen    <= MEM_EN_ON;
                            mem_datain <= win_wdata;
                        end else begin
                            mem_oen <= MEM_EN_ON;
                        end
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (we_l) begin
                        mem_cen <= MEM_EN_OFF;
                        mem_wen <= MEM_EN_OFF;
                        done    <= owner;
                        state   <= ST_DRAIN;
                    end else if (cnt == len_l) begin
                        mem_cen <= MEM_EN_OFF;
                        mem_oen <= MEM_EN_OFF;
                        state   <= ST_DRAIN;
                    end else begin
                        cnt      <= cnt + LEN_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    // Leave once nothing is in flight below the return stage; a word in
                    // the top stage is being delivered in this same cycle.
                    if ((rd_pipe << 1) == '0) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
